// File: rtl/cassette_fsk_tx_if.sv
// Byte handshake between a tape byte source and the cassette FSK transmitter.
interface cassette_fsk_tx_if;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_data, output byte_valid, input byte_ready);
  modport slave  (input byte_data, input byte_valid, output byte_ready);
endinterface

// File: rtl/cassette_fsk_tx.sv
// Cassette FSK transmitter: serialises bytes LSB first as one square-wave cycle per bit,
// 1200 Hz for a "1" and 2400 Hz for a "0", with a one-byte holding register for streaming.
module cassette_fsk_tx #(
  parameter int          HALF_ONE  = 17898,
  parameter int          HALF_ZERO = 8949,
  parameter logic [11:0] SND_LEVEL = 12'd1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              motor,
  input  logic              play,
  cassette_fsk_tx_if.slave  tx,
  output logic              casdout,
  output logic [11:0]       cass_snd,
  output logic              busy,
  output logic              underrun
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;
  localparam logic [1:0] LOW  = 2'd3;

  localparam logic [15:0] LOAD_ONE  = 16'(HALF_ONE - 1);
  localparam logic [15:0] LOAD_ZERO = 16'(HALF_ZERO - 1);

  logic [1:0]  state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [2:0]  idx_reg, idx_next;
  logic [7:0]  shift_reg, shift_next;
  logic [7:0]  hold_reg, hold_next;
  logic        hold_full_reg, hold_full_next;
  logic        casdout_reg;
  logic [11:0] cass_snd_reg, cass_snd_next;
  logic        underrun_reg, underrun_next;

  logic        run;
  logic        accept;
  logic [7:0]  next_byte;

  function automatic logic [15:0] half_load(input logic bit_val);
    return bit_val ? LOAD_ONE : LOAD_ZERO;
  endfunction

  assign run           = motor & play;
  assign tx.byte_ready = ~hold_full_reg & run;
  assign accept        = tx.byte_valid & tx.byte_ready;
  // A byte accepted on the very clk bit 7 ends is forwarded straight into the shifter.
  assign next_byte     = hold_full_reg ? hold_reg : tx.byte_data;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    idx_next       = idx_reg;
    shift_next     = shift_reg;
    hold_next      = hold_reg;
    hold_full_next = hold_full_reg;
    underrun_next  = 1'b0;

    if (accept) begin
      hold_next      = tx.byte_data;
      hold_full_next = 1'b1;
    end

    if (!run) begin
      state_next = IDLE;
      cnt_next   = 16'd0;
      idx_next   = 3'd0;
      shift_next = 8'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (hold_full_reg) state_next = LOAD;
        end
        LOAD: begin
          shift_next     = hold_reg;
          hold_full_next = 1'b0;
          idx_next       = 3'd0;
          cnt_next       = half_load(hold_reg[0]);
          state_next     = HIGH;
        end
        HIGH: begin
          if (cnt_reg == 16'd0) begin
            cnt_next   = half_load(shift_reg[0]);
            state_next = LOW;
          end else begin
            cnt_next = cnt_reg - 16'd1;
          end
        end
        LOW: begin
          if (cnt_reg != 16'd0) begin
            cnt_next = cnt_reg - 16'd1;
          end else if (idx_reg != 3'd7) begin
            shift_next = {1'b0, shift_reg[7:1]};
            idx_next   = idx_reg + 3'd1;
            cnt_next   = half_load(shift_reg[1]);
            state_next = HIGH;
          end else if (hold_full_reg || accept) begin
            shift_next     = next_byte;
            hold_full_next = 1'b0;
            idx_next       = 3'd0;
            cnt_next       = half_load(next_byte[0]);
            state_next     = HIGH;
          end else begin
            underrun_next = 1'b1;
            state_next    = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Output level is decided from the next state so casdout/cass_snd come straight from flops.
  genvar gi;
  generate
    for (gi = 0; gi < 12; gi++) begin : g_snd
      assign cass_snd_next[gi] = (state_next == HIGH) & SND_LEVEL[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= 16'd0;
      idx_reg       <= 3'd0;
      shift_reg     <= 8'd0;
      hold_reg      <= 8'd0;
      hold_full_reg <= 1'b0;
      casdout_reg   <= 1'b0;
      cass_snd_reg  <= 12'd0;
      underrun_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      idx_reg       <= idx_next;
      shift_reg     <= shift_next;
      hold_reg      <= hold_next;
      hold_full_reg <= hold_full_next;
      casdout_reg   <= (state_next == HIGH);
      cass_snd_reg  <= cass_snd_next;
      underrun_reg  <= underrun_next;
    end
  end

  assign casdout  = casdout_reg;
  assign cass_snd = cass_snd_reg;
  assign busy     = (state_reg != IDLE);
  assign underrun = underrun_reg;

endmodule

// File: tb/tb_cassette_fsk_tx.sv
// Directed bench for cassette_fsk_tx with HALF_ONE=4, HALF_ZERO=2.
module tb_cassette_fsk_tx;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        motor;
  logic        play;
  logic        casdout;
  logic [11:0] cass_snd;
  logic        busy;
  logic        underrun;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cassette_fsk_tx_if bus ();

  cassette_fsk_tx #(
    .HALF_ONE (4),
    .HALF_ZERO(2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .motor   (motor),
    .play    (play),
    .tx      (bus.slave),
    .casdout (casdout),
    .cass_snd(cass_snd),
    .busy    (busy),
    .underrun(underrun)
  );

  // Reference waveform: per bit, h highs then h lows, h = 4 for a 1 and 2 for a 0, LSB first.
  function automatic logic [255:0] exp_wave(input logic [7:0] b0, input logic [7:0] b1, input int nb);
    logic [255:0] w;
    logic [7:0]   b;
    int           p;
    int           h;
    w = '0;
    p = 0;
    for (int k = 0; k < nb; k++) begin
      b = (k == 0) ? b0 : b1;
      for (int i = 0; i < 8; i++) begin
        h = b[i] ? 4 : 2;
        for (int j = 0; j < h; j++) begin w[p] = 1'b1; p++; end
        for (int j = 0; j < h; j++) begin w[p] = 1'b0; p++; end
      end
    end
    return w;
  endfunction

  // Records casdout over n cycles, counts underrun cycles and cass_snd/casdout disagreements.
  task automatic capture(input int n, output logic [255:0] w, output int und, output int snd_bad);
    w = '0;
    und = 0;
    snd_bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      w[i] = casdout;
      if (underrun !== 1'b0) und++;
      if (cass_snd !== (casdout ? 12'd1024 : 12'd0)) snd_bad++;
    end
  endtask

  task automatic offer(input logic [7:0] b);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    motor = 1'b0;
    play = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({casdout, cass_snd, busy, underrun} !== 15'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got casdout=%b snd=%0d busy=%b underrun=%b, want all 0", casdout, cass_snd, busy, underrun);
    end
    vectors++;
    if (bus.byte_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready_norun: got %b want 0", bus.byte_ready);
    end
    motor = 1'b1;
    play = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.byte_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: got ready=%b busy=%b want ready=1 busy=0", bus.byte_ready, busy);
    end
    $display("test_reset: reset applied and released");
  endtask

  task automatic test_single_byte;
    logic [255:0] w;
    int und, sb;
    @(negedge clk);
    offer(8'h01);
    @(negedge clk);
    vectors++;
    if (bus.byte_ready !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_held: got ready=%b busy=%b want ready=0 busy=0", bus.byte_ready, busy);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1 || casdout !== 1'b0) begin
      miscompares++;
      $display("FAIL single_load: got busy=%b casdout=%b want busy=1 casdout=0", busy, casdout);
    end
    capture(36, w, und, sb);
    vectors++;
    if (w !== exp_wave(8'h01, 8'h00, 1)) begin
      miscompares++;
      $display("FAIL single_wave: got %h want %h", w[35:0], exp_wave(8'h01, 8'h00, 1));
    end
    vectors++;
    if (und !== 0 || sb !== 0) begin
      miscompares++;
      $display("FAIL single_side: got underrun_cycles=%0d snd_bad=%0d want 0 0", und, sb);
    end
    @(negedge clk);
    vectors++;
    if (underrun !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_underrun: got underrun=%b busy=%b want 1 0", underrun, busy);
    end
    @(negedge clk);
    vectors++;
    if (underrun !== 1'b0) begin
      miscompares++;
      $display("FAIL single_pulse_width: got underrun=%b want 0", underrun);
    end
    $display("test_single_byte: byte 01 sent");
  endtask

  task automatic test_back_to_back;
    logic [255:0] w;
    int und, sb;
    offer(8'h55);
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (bus.byte_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_ready_before_load: got %b want 0", bus.byte_ready);
    end
    @(posedge clk);
    #1;
    bus.byte_valid = 1'b1;
    bus.byte_data = 8'hAA;
    vectors++;
    if (bus.byte_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_ready_after_load: got %b want 1", bus.byte_ready);
    end
    fork
      capture(96, w, und, sb);
      begin
        @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;
      end
    join
    vectors++;
    if (w !== exp_wave(8'h55, 8'hAA, 2)) begin
      miscompares++;
      $display("FAIL b2b_wave: got %h want %h", w[95:0], exp_wave(8'h55, 8'hAA, 2));
    end
    vectors++;
    if (und !== 0 || sb !== 0) begin
      miscompares++;
      $display("FAIL b2b_side: got underrun_cycles=%0d snd_bad=%0d want 0 0", und, sb);
    end
    @(negedge clk);
    vectors++;
    if (underrun !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_end: got underrun=%b busy=%b want 1 0", underrun, busy);
    end
    $display("test_back_to_back: bytes 55 AA streamed");
  endtask

  task automatic test_motor_drop;
    logic [255:0] w;
    logic [255:0] e;
    int und, sb;
    offer(8'hFF);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    bus.byte_valid = 1'b1;
    bus.byte_data = 8'h81;
    fork
      capture(28, w, und, sb);
      begin
        @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;
      end
    join
    e = exp_wave(8'hFF, 8'h00, 1);
    for (int i = 28; i < 256; i++) e[i] = 1'b0;
    vectors++;
    if (w !== e) begin
      miscompares++;
      $display("FAIL drop_partial_wave: got %h want %h", w[27:0], e[27:0]);
    end
    motor = 1'b0;
    @(negedge clk);
    vectors++;
    if (casdout !== 1'b0 || busy !== 1'b0 || underrun !== 1'b0 || bus.byte_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_idle: got casdout=%b busy=%b underrun=%b ready=%b want 0 0 0 0", casdout, busy, underrun, bus.byte_ready);
    end
    capture(6, w, und, sb);
    vectors++;
    if (w !== '0 || und !== 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_quiet: got wave=%h underrun_cycles=%0d busy=%b want 0 0 0", w[5:0], und, busy);
    end
    motor = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1 || casdout !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_resume_load: got busy=%b casdout=%b want 1 0", busy, casdout);
    end
    capture(40, w, und, sb);
    vectors++;
    if (w !== exp_wave(8'h81, 8'h00, 1) || und !== 0 || sb !== 0) begin
      miscompares++;
      $display("FAIL drop_held_byte: got %h und=%0d snd_bad=%0d want %h 0 0", w[39:0], und, sb, exp_wave(8'h81, 8'h00, 1));
    end
    @(negedge clk);
    vectors++;
    if (underrun !== 1'b1) begin
      miscompares++;
      $display("FAIL drop_end_underrun: got %b want 1", underrun);
    end
    $display("test_motor_drop: FF cut in bit 3, held 81 resent");
  endtask

  task automatic test_play_off;
    logic [255:0] w;
    int und, sb;
    play = 1'b0;
    bus.byte_valid = 1'b1;
    bus.byte_data = 8'h3C;
    #1;
    vectors++;
    if (bus.byte_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL playoff_ready: got %b want 0", bus.byte_ready);
    end
    capture(5, w, und, sb);
    vectors++;
    if (w !== '0 || und !== 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL playoff_quiet: got wave=%h und=%0d busy=%b want 0 0 0", w[4:0], und, busy);
    end
    bus.byte_valid = 1'b0;
    play = 1'b1;
    #1;
    vectors++;
    if (bus.byte_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL playoff_not_accepted: got ready=%b want 1", bus.byte_ready);
    end
    capture(4, w, und, sb);
    vectors++;
    if (w !== '0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL playoff_no_send: got wave=%h busy=%b want 0 0", w[3:0], busy);
    end
    $display("test_play_off: byte 3C offered with play low");
  endtask

  task automatic test_edge_offer;
    logic [255:0] w1;
    logic [255:0] w2;
    int und1, sb1, und2, sb2;
    @(negedge clk);
    offer(8'h0F);
    @(negedge clk);
    @(negedge clk);
    capture(47, w1, und1, sb1);
    @(posedge clk);
    #1;
    bus.byte_valid = 1'b1;
    bus.byte_data = 8'hF0;
    vectors++;
    if (bus.byte_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL edge_ready: got %b want 1", bus.byte_ready);
    end
    fork
      capture(49, w2, und2, sb2);
      begin
        @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;
      end
    join
    vectors++;
    if ((w1 | (w2 << 47)) !== exp_wave(8'h0F, 8'hF0, 2)) begin
      miscompares++;
      $display("FAIL edge_wave: got %h want %h", (w1 | (w2 << 47)), exp_wave(8'h0F, 8'hF0, 2));
    end
    vectors++;
    if (und1 + und2 !== 0 || sb1 + sb2 !== 0) begin
      miscompares++;
      $display("FAIL edge_side: got underrun_cycles=%0d snd_bad=%0d want 0 0", und1 + und2, sb1 + sb2);
    end
    @(negedge clk);
    vectors++;
    if (underrun !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL edge_end: got underrun=%b busy=%b want 1 0", underrun, busy);
    end
    $display("test_edge_offer: F0 offered on last LOW clk of 0F");
  endtask

  task automatic test_reset_mid;
    logic [255:0] w;
    int und, sb;
    offer(8'hFF);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    bus.byte_valid = 1'b1;
    bus.byte_data = 8'hC3;
    fork
      capture(3, w, und, sb);
      begin
        @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;
      end
    join
    vectors++;
    if (w[2:0] !== 3'b111 || bus.byte_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_pre: got wave=%b ready=%b want 111 0", w[2:0], bus.byte_ready);
    end
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({casdout, cass_snd, busy, underrun} !== 15'd0) begin
      miscompares++;
      $display("FAIL rstmid_async: got casdout=%b snd=%0d busy=%b underrun=%b want all 0", casdout, cass_snd, busy, underrun);
    end
    vectors++;
    if (bus.byte_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_hold_cleared: got ready=%b want 1", bus.byte_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    capture(6, w, und, sb);
    vectors++;
    if (w !== '0 || busy !== 1'b0 || und !== 0) begin
      miscompares++;
      $display("FAIL rstmid_after: got wave=%h busy=%b und=%0d want 0 0 0", w[5:0], busy, und);
    end
    $display("test_reset_mid: reset asserted during HIGH of FF");
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_motor_drop();
    test_play_off();
    test_edge_offer();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cassette_fsk_tx.md
CASSETTE_FSK_TX -- requirements
Module: cassette_fsk_tx

Interface
REQ-001 Parameter HALF_ONE, default 17898: clk cycles per half-period of a "1" bit (1200 Hz at 42.954 MHz).
REQ-002 Parameter HALF_ZERO, default 8949: clk cycles per half-period of a "0" bit (2400 Hz at 42.954 MHz).
REQ-003 Parameter SND_LEVEL, default 12'd1024: cass_snd amplitude while casdout is high.
REQ-004 clk  in  1  system clock (42.954 MHz); the block's only clock.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 motor  in  1  cassette relay (PIA1 CA2); high means the tape runs.
REQ-007 play  in  1  user play enable; transmission requires motor & play.
REQ-008 byte_data  in  8  next tape byte.
REQ-009 byte_valid  in  1  byte_data is valid.
REQ-010 byte_ready  out  1  holding register empty; a byte is accepted on clk when byte_valid & byte_ready.
REQ-011 casdout  out  1  FSK square wave to PIA1 port A bit 0.
REQ-012 cass_snd  out  12  audible copy of casdout for the dac.
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 underrun  out  1  one-clk pulse when the shifter empties with no byte held while running.

Function
REQ-015 States SHALL be IDLE, LOAD, HIGH and LOW; a 16-bit half-period counter, a 3-bit bit index, an 8-bit shift register, an 8-bit holding register and a hold_full flag.
REQ-016 run = motor & play; byte_ready = ~hold_full & run.
REQ-017 Accept: byte_data latches into the holding register and hold_full sets on the same edge.
REQ-018 IDLE -> LOAD when run & hold_full; LOAD copies holding to shift, clears hold_full, sets bit index to 0, loads the counter, and enters HIGH (1 clk).
REQ-019 Bits SHALL go out LSB first; each bit is one full cycle: HIGH (casdout=1) then LOW (casdout=0), each lasting HALF_ONE cycles if the current bit is 1 and HALF_ZERO cycles if it is 0.
REQ-020 The counter SHALL load with (half-1) on entry to HIGH or LOW and decrement; the state advances on the clk where the counter equals 0.
REQ-021 At the end of LOW for bit index 0-6: shift right, increment the index, and enter HIGH.
REQ-022 At the end of LOW for bit index 7 with hold_full=1: load the next byte directly and enter HIGH, with no LOAD gap, so back-to-back bytes are seamless.
REQ-023 At the end of LOW for bit index 7 with hold_full=0: pulse underrun and enter IDLE.
REQ-024 If a byte is accepted on the same clk as bit 7 ends, the transfer SHALL use that byte (forwarded) and continue seamlessly.
REQ-025 If run falls in any state, the block SHALL enter IDLE on the next edge, set casdout=0, discard the shift contents, and keep the holding register (no underrun pulse).
REQ-026 In IDLE and LOAD casdout SHALL be 0.
REQ-027 cass_snd = SND_LEVEL when casdout=1, else 0; both outputs are registered.
REQ-028 A byte_valid asserted while byte_ready=0 SHALL be ignored; byte_data need not be held.

Reset
REQ-029 reset_n low SHALL asynchronously force IDLE, counter=0, index=0, shift=0, hold=0, hold_full=0, casdout=0, cass_snd=0, busy=0, underrun=0; byte_ready follows run after release.
REQ-030 Reset asserted mid-bit SHALL truncate the waveform immediately, with no partial cycle after release.

Verification
REQ-031 Use HALF_ONE=4 and HALF_ZERO=2. Set motor=play=1 and send byte 8'h01. Expect casdout pattern 1111 0000 then seven times 11 00, then busy=0 and one underrun pulse.
REQ-032 Stream 8'h55 then 8'hAA, with the second offered while the first is transmitting. Expect 16 contiguous bit cycles with no idle clk between bytes, and byte_ready low until the first byte reaches LOAD.
REQ-033 Drop motor during bit 3 of 8'hFF. Expect casdout=0 and IDLE next clk, no underrun pulse, and a held byte retained and sent after motor rises again.
REQ-034 Set play=0 and offer byte_valid with 8'h3C. Expect byte_ready=0, no acceptance and casdout constant 0.
REQ-035 Offer the next byte exactly on the final LOW clk of bit 7. Expect seamless continuation and no underrun pulse.
REQ-036 Assert reset_n low mid-HIGH. Expect all outputs at reset values asynchronously, before the next clk edge.
